// File: rtl/sram4k8_master.sv
// Arbitrating master for a 4Kx8 synchronous SRAM (registered read): CPU single accesses plus scan bursts.
// Define SRAM4K8_MASTER_PREEMPT_EN to let CPU strobes slot in between scan strobes.
module sram4k8_master #(
    parameter int SCAN_LEN = 32
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WE,
    input  logic [11:0] i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DIN,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_CPU_DOUT,
    input  logic        i_SCAN_START,
    input  logic [11:0] i_SCAN_BASE,
    output logic        o_SCAN_VALID,
    output logic [7:0]  o_SCAN_DATA,
    output logic        o_SCAN_BUSY,
    output logic [11:0] o_SRAM_ADDR,
    output logic [7:0]  o_SRAM_DIN,
    output logic        o_SRAM_WR_n,
    output logic        o_SRAM_RD_n,
    input  logic [7:0]  i_SRAM_DOUT
);

    localparam logic [11:0] LEN_M1 = 12'(SCAN_LEN - 1);

    typedef enum logic [1:0] {IDLE, SCAN, CPU_WR, CPU_RD} state_t;

    state_t      state;
    logic [11:0] scan_addr;
    logic [11:0] scan_rem;
    logic        scan_last_q;

    // Per-strobe tags: _p0 travels with the strobe, _p1 with the SRAM's returned byte.
    logic        vld_p0, cpu_p0, last_p0;
    logic        vld_p1, cpu_p1, last_p1;

    logic        cpu_inflight;
    logic        cpu_go;
    logic        scan_go;

    // A CPU access is outstanding from its strobe through its ACK; a held REQ is only re-taken afterwards.
    assign cpu_inflight = !o_SRAM_WR_n || (vld_p0 && cpu_p0) || (vld_p1 && cpu_p1) || o_CPU_ACK;
    assign cpu_go       = i_CPU_REQ && !cpu_inflight;
    assign scan_go      = i_SCAN_START && !o_SCAN_BUSY;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state        <= IDLE;
            scan_addr    <= '0;
            scan_rem     <= '0;
            scan_last_q  <= 1'b0;
            vld_p0       <= 1'b0;
            cpu_p0       <= 1'b0;
            last_p0      <= 1'b0;
            vld_p1       <= 1'b0;
            cpu_p1       <= 1'b0;
            last_p1      <= 1'b0;
            o_SRAM_ADDR  <= '0;
            o_SRAM_DIN   <= '0;
            o_SRAM_WR_n  <= 1'b1;
            o_SRAM_RD_n  <= 1'b1;
            o_CPU_ACK    <= 1'b0;
            o_CPU_DOUT   <= '0;
            o_SCAN_VALID <= 1'b0;
            o_SCAN_DATA  <= '0;
            o_SCAN_BUSY  <= 1'b0;
        end else begin
            o_SRAM_WR_n <= 1'b1;
            o_SRAM_RD_n <= 1'b1;
            vld_p0      <= 1'b0;
            cpu_p0      <= 1'b0;
            last_p0     <= 1'b0;

            // ---- p0 -> p1: SRAM registers the read during this stage ----
            vld_p1  <= vld_p0;
            cpu_p1  <= cpu_p0;
            last_p1 <= last_p0;

            // ---- p1 -> output: capture i_SRAM_DOUT and route by tag ----
            o_CPU_ACK    <= !o_SRAM_WR_n || (vld_p1 && cpu_p1);
            o_SCAN_VALID <= vld_p1 && !cpu_p1;
            if (vld_p1 && cpu_p1)
                o_CPU_DOUT <= i_SRAM_DOUT;
            if (vld_p1 && !cpu_p1) begin
                o_SCAN_DATA <= i_SRAM_DOUT;
                scan_last_q <= last_p1;
            end
            if (o_SCAN_VALID && scan_last_q)
                o_SCAN_BUSY <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (scan_go) begin
                        o_SRAM_RD_n <= 1'b0;
                        o_SRAM_ADDR <= i_SCAN_BASE;
                        vld_p0      <= 1'b1;
                        last_p0     <= (LEN_M1 == 12'd0);
                        scan_addr   <= i_SCAN_BASE + 12'd1;
                        scan_rem    <= LEN_M1;
                        o_SCAN_BUSY <= 1'b1;
                        state       <= SCAN;
                    end else if (cpu_go) begin
                        o_SRAM_ADDR <= i_CPU_ADDR;
                        if (i_CPU_WE) begin
                            o_SRAM_WR_n <= 1'b0;
                            o_SRAM_DIN  <= i_CPU_DIN;
                            state       <= CPU_WR;
                        end else begin
                            o_SRAM_RD_n <= 1'b0;
                            vld_p0      <= 1'b1;
                            cpu_p0      <= 1'b1;
                            state       <= CPU_RD;
                        end
                    end
                end
                SCAN: begin
`ifdef SRAM4K8_MASTER_PREEMPT_EN
                    if (cpu_go && scan_rem != 12'd0) begin
                        o_SRAM_ADDR <= i_CPU_ADDR;
                        if (i_CPU_WE) begin
                            o_SRAM_WR_n <= 1'b0;
                            o_SRAM_DIN  <= i_CPU_DIN;
                        end else begin
                            o_SRAM_RD_n <= 1'b0;
                            vld_p0      <= 1'b1;
                            cpu_p0      <= 1'b1;
                        end
                    end else
`endif
                    if (scan_rem != 12'd0) begin
                        o_SRAM_RD_n <= 1'b0;
                        o_SRAM_ADDR <= scan_addr;
                        vld_p0      <= 1'b1;
                        last_p0     <= (scan_rem == 12'd1);
                        scan_addr   <= scan_addr + 12'd1;
                        scan_rem    <= scan_rem - 12'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CPU_WR:  state <= IDLE;
                CPU_RD:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
